// File: rtl/rand_interval_timer_pkg.sv
// Shared types and default widths for the random interval timer slice.
package rand_timer_pkg;

  localparam int unsigned RND_W_DEF = 14;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ID_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    FIRE  = 2'd3
  } timer_state_t;

endpackage

// File: rtl/rand_interval_timer_if.sv
// Event handshake bundle: the timer drives valid/id/delay, the consumer drives ready.
interface rand_interval_timer_if
  import rand_timer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
);

  logic             evt_valid;
  logic             evt_ready;
  logic [ID_W-1:0]  evt_id;
  logic [CNT_W-1:0] evt_delay;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_delay,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_delay,
    output evt_ready
  );

endinterface

// File: rtl/rand_interval_calc.sv
// Interval = min_gap + (rnd_in & range_mask), saturating at all-ones. Assumes CNT_W >= RND_W.
module rand_interval_calc
  import rand_timer_pkg::*;
#(
  parameter int unsigned RND_W = RND_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic [RND_W-1:0] rnd_in,
  input  logic [RND_W-1:0] range_mask,
  input  logic [CNT_W-1:0] min_gap,
  output logic [CNT_W-1:0] delay
);

  logic [RND_W-1:0] masked;
  logic [CNT_W:0]   sum;

  always_comb begin
    masked = rnd_in & range_mask;
    sum    = {1'b0, min_gap} + (CNT_W+1)'(masked);
    delay  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

endmodule

// File: rtl/rand_interval_timer.sv
// Turns the LFSR word into randomly spaced events offered over a valid/ready handshake.
module rand_interval_timer
  import rand_timer_pkg::*;
#(
  parameter int unsigned RND_W = RND_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [RND_W-1:0]      rnd_in,
  input  logic [CNT_W-1:0]      min_gap,
  input  logic [RND_W-1:0]      range_mask,
  output logic                  busy,
  rand_interval_timer_if.master evt
);

  timer_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] calc_delay;

  rand_interval_calc #(
    .RND_W (RND_W),
    .CNT_W (CNT_W)
  ) u_calc (
    .rnd_in     (rnd_in),
    .range_mask (range_mask),
    .min_gap    (min_gap),
    .delay      (calc_delay)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = calc_delay;
        delay_d = calc_delay;
        state_d = (calc_delay == '0) ? FIRE : COUNT;
      end
      COUNT: begin
        // Abort takes priority over the final 1->0 step.
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIRE;
        end
      end
      FIRE: begin
        if (evt.evt_ready) begin
          id_d    = id_q + ID_W'(1);
          state_d = enable ? LOAD : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    evt.evt_valid = (state_q == FIRE);
    evt.evt_id    = id_q;
    evt.evt_delay = delay_q;
    busy          = (state_q != IDLE);
  end

  a_valid_held: assert property (@(posedge clk) disable iff (reset)
    (evt.evt_valid && !evt.evt_ready) |=> evt.evt_valid);

endmodule

// File: tb/tb_rand_interval_timer.sv
// Scoreboard bench: stimulus queues expected events, a monitor pops them on each accept.
module tb_rand_interval_timer;
  import rand_timer_pkg::*;

  localparam int unsigned RND_W = 14;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ID_W  = 8;

  typedef struct {
    int id;
    int delay;
    int rise;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [RND_W-1:0] rnd_in = '0;
  logic [CNT_W-1:0] min_gap = '0;
  logic [RND_W-1:0] range_mask = '0;
  logic             busy;

  rand_interval_timer_if #(.CNT_W(CNT_W), .ID_W(ID_W)) evt_if ();

  rand_interval_timer #(
    .RND_W (RND_W),
    .CNT_W (CNT_W),
    .ID_W  (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rnd_in     (rnd_in),
    .min_gap    (min_gap),
    .range_mask (range_mask),
    .busy       (busy),
    .evt        (evt_if.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_valid = 1'b0;
  int   rise_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor samples 2ns after the falling edge, clear of both clock edges and stimulus updates.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (evt_if.evt_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = evt_if.evt_valid;
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: got id %0d delay %0h with no expected entry (cycle %0d)",
                   evt_if.evt_id, evt_if.evt_delay, cyc);
        end else begin
          e = q.pop_front();
          check("evt_id", 32'(evt_if.evt_id), e.id);
          check("evt_delay", 32'(evt_if.evt_delay), e.delay);
          if (e.rise >= 0) check("evt_rise_cycle", rise_cyc, e.rise);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic start_run(input logic [CNT_W-1:0] g, input logic [RND_W-1:0] m,
                           input logic [RND_W-1:0] r, input logic rdy, output int load_c);
    min_gap = g;
    range_mask = m;
    rnd_in = r;
    evt_if.evt_ready = rdy;
    enable = 1'b1;
    load_c = cyc + 1;
  endtask

  task automatic wait_accepts(input int n, input int budget, input string name);
    int cnt = 0;
    int t = 0;
    while (cnt < n && t < budget) begin
      tick(1);
      t++;
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        cnt++;
        if (cnt == n) enable = 1'b0;
      end
    end
    if (cnt < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d accepts expected %0d", name, cnt, n);
      enable = 1'b0;
    end
    tick(2);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int t = 0;
    while (!evt_if.evt_valid && t < budget) begin
      tick(1);
      t++;
    end
    if (!evt_if.evt_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got evt_valid 0 expected 1 within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int L;
    evt_if.evt_ready = 1'b0;

    // Reset state
    tick(1);
    do_reset();
    check("rst_valid", 32'(evt_if.evt_valid), 0);
    check("rst_id", 32'(evt_if.evt_id), 0);
    check("rst_delay", 32'(evt_if.evt_delay), 0);
    check("rst_busy", 32'(busy), 0);

    // 1: fixed gap of 3, two events
    start_run(16'd3, '0, 14'h2AAA, 1'b1, L);
    q.push_back('{0, 3, L + 4});
    q.push_back('{1, 3, L + 9});
    wait_accepts(2, 40, "t1");
    check("t1_busy_after", 32'(busy), 0);

    // 2: delay 0, back-to-back every other cycle
    do_reset();
    start_run('0, '0, '0, 1'b1, L);
    for (int i = 0; i < 4; i++) q.push_back('{i, 0, L + 1 + 2 * i});
    wait_accepts(4, 40, "t2");

    // 3: back-pressure holds the event stable, then exactly one accept
    start_run(16'd2, '0, 14'h3FFF, 1'b0, L);
    q.push_back('{4, 2, L + 3});
    wait_valid(20, "t3");
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t3_hold_valid", 32'(evt_if.evt_valid), 1);
      check("t3_hold_id", 32'(evt_if.evt_id), 4);
      check("t3_hold_delay", 32'(evt_if.evt_delay), 2);
    end
    evt_if.evt_ready = 1'b1;
    enable = 1'b0;
    tick(1);
    check("t3_valid_after", 32'(evt_if.evt_valid), 0);
    check("t3_id_after", 32'(evt_if.evt_id), 5);
    check("t3_busy_after", 32'(busy), 0);
    tick(4);

    // 4a: saturation, then abort out of the long count
    start_run(16'hFFF0, 14'h3FFF, 14'h0100, 1'b1, L);
    tick(1);
    enable = 1'b0;
    tick(1);
    check("t4a_delay", 32'(evt_if.evt_delay), 32'hFFFF);
    check("t4a_busy_count", 32'(busy), 1);
    tick(1);
    check("t4a_busy_abort", 32'(busy), 0);
    check("t4a_delay_kept", 32'(evt_if.evt_delay), 32'hFFFF);

    // 4b: near-saturation without overflow
    start_run(16'hFFF0, 14'h000F, 14'h1235, 1'b1, L);
    tick(1);
    enable = 1'b0;
    tick(1);
    check("t4b_delay", 32'(evt_if.evt_delay), 32'hFFF5);
    tick(1);
    check("t4b_busy_abort", 32'(busy), 0);

    // 4c: masked offset 0x30 + 2 = 50; inputs changed after LOAD must not matter
    start_run(16'd2, 14'h00F0, 14'h1235, 1'b1, L);
    q.push_back('{5, 50, L + 51});
    tick(2);
    min_gap = '0;
    range_mask = '0;
    rnd_in = '0;
    wait_accepts(1, 80, "t4c");

    // 4d: rnd_in 0 gives delay = min_gap
    start_run(16'd5, 14'h3FFF, '0, 1'b1, L);
    q.push_back('{6, 5, L + 6});
    wait_accepts(1, 30, "t4d");

    // 5a: abort two cycles into the count of a delay-10 interval
    start_run(16'd10, '0, '0, 1'b1, L);
    tick(3);
    enable = 1'b0;
    tick(1);
    check("t5a_busy", 32'(busy), 0);
    check("t5a_valid", 32'(evt_if.evt_valid), 0);
    check("t5a_id", 32'(evt_if.evt_id), 7);
    check("t5a_delay_kept", 32'(evt_if.evt_delay), 10);
    tick(15);
    check("t5a_no_event", 32'(evt_if.evt_valid), 0);

    // 5b: reset while an event is pending discards it
    start_run(16'd1, '0, '0, 1'b0, L);
    wait_valid(10, "t5b");
    check("t5b_pending_id", 32'(evt_if.evt_id), 7);
    reset = 1'b1;
    tick(1);
    check("t5b_valid", 32'(evt_if.evt_valid), 0);
    check("t5b_id", 32'(evt_if.evt_id), 0);
    check("t5b_busy", 32'(busy), 0);
    check("t5b_delay", 32'(evt_if.evt_delay), 0);
    enable = 1'b0;
    reset = 1'b0;
    tick(2);

    // 6: id wrap across 257 continuous events
    start_run('0, '0, '0, 1'b1, L);
    for (int i = 0; i < 257; i++) q.push_back('{i % 256, 0, L + 1 + 2 * i});
    wait_accepts(257, 600, "t6");
    check("t6_final_id", 32'(evt_if.evt_id), 1);

    tick(5);
    check("scoreboard_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
